// File: rtl/pixel_wb_sequencer.sv
// pixel_wb_sequencer: Wishbone initiator that steps the pixel macro through N frames.
// Define PXL_SEQ_READBACK_EN to read the control register back after each clear write.
module pixel_wb_sequencer #(
  parameter logic [31:0] ADDR         = 32'h3000_0000,
  parameter int          FRAME_W      = 8,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          DONE_TIMEOUT = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               run_i,
  input  logic [FRAME_W-1:0] frames_i,
  input  logic [23:0]        cfg_i,
  input  logic               pxl_done_i,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [3:0]         wbm_sel_o,
  output logic [31:0]        wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [31:0]        wbm_dat_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);
  localparam int AW = $clog2(ACK_TIMEOUT + 2);
  localparam int DW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_START, WAIT_DONE, WR_CLR, RD_CHK, NEXT, FIN} state_t;

  state_t             state, state_nx;
  logic               cyc_q, cyc_nx;
  logic [AW-1:0]      atmr;
  logic [DW-1:0]      dtmr;
  logic [22:0]        cfg_q;
  logic [FRAME_W-1:0] frames_q, frame_cnt, tgt, cnt_p1;
  logic               err_q, err_set;
  logic [1:0]         code_q, code_set;
  logic               accept, cnt_inc, ack_to, rb_bad;
  logic [31:0]        wr_word;
  logic               unused_cfg0;

  assign unused_cfg0 = cfg_i[0];
  assign tgt    = (frames_q == '0) ? FRAME_W'(1) : frames_q;
  assign cnt_p1 = frame_cnt + FRAME_W'(1);
  // atmr equals the index of the current stb-high cycle, so an ack on cycle ACK_TIMEOUT still lands
  assign ack_to = (atmr == AW'(ACK_TIMEOUT + 1));

`ifdef PXL_SEQ_READBACK_EN
  assign rb_bad = (wbm_dat_i[24:0] != {1'b0, cfg_q, 1'b0});
`else
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;
  assign rb_bad     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc_q;
    accept   = 1'b0;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    code_set = 2'b00;
    case (state)
      IDLE: if (run_i) begin
        accept   = 1'b1;
        state_nx = WR_START;
      end
      WR_START, WR_CLR, RD_CHK: begin
        // each bus state spends one idle cycle before raising cyc/stb
        if (!cyc_q) cyc_nx = 1'b1;
        else if (wbm_ack_i) begin
          cyc_nx = 1'b0;
          if (state == WR_START) state_nx = WAIT_DONE;
          else if (state == WR_CLR) begin
`ifdef PXL_SEQ_READBACK_EN
            state_nx = RD_CHK;
`else
            state_nx = NEXT;
`endif
          end else if (rb_bad) begin
            state_nx = FIN;
            err_set  = 1'b1;
            code_set = 2'b11;
          end else state_nx = NEXT;
        end else if (ack_to) begin
          cyc_nx   = 1'b0;
          state_nx = FIN;
          err_set  = 1'b1;
          code_set = 2'b01;
        end
      end
      WAIT_DONE: begin
        if (pxl_done_i) state_nx = WR_CLR;
        else if (dtmr == DW'(DONE_TIMEOUT - 1)) begin
          state_nx = FIN;
          err_set  = 1'b1;
          code_set = 2'b10;
        end
      end
      NEXT: begin
        cnt_inc  = 1'b1;
        state_nx = (cnt_p1 == tgt) ? FIN : WR_START;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cyc_q     <= 1'b0;
      atmr      <= '0;
      dtmr      <= '0;
      cfg_q     <= '0;
      frames_q  <= '0;
      frame_cnt <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state <= state_nx;
      cyc_q <= cyc_nx;
      if (!cyc_q) atmr <= AW'(1);
      else if (!ack_to) atmr <= atmr + 1'b1;
      dtmr <= (state == WAIT_DONE) ? dtmr + 1'b1 : '0;
      if (accept) begin
        cfg_q     <= cfg_i[23:1];
        frames_q  <= frames_i;
        frame_cnt <= '0;
        err_q     <= 1'b0;
        code_q    <= 2'b00;
      end
      if (cnt_inc && frame_cnt != '1) frame_cnt <= cnt_p1;
      if (err_set && !err_q) begin
        err_q  <= 1'b1;
        code_q <= code_set;
      end
    end
  end

  assign wr_word     = {8'h00, cfg_q, state == WR_START};
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cyc_q && (state != RD_CHK);
  assign wbm_sel_o   = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o   = cyc_q ? ADDR : 32'h0;
  assign wbm_dat_o   = wbm_we_o ? wr_word : 32'h0;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == FIN) && !err_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;
  assign frame_cnt_o = frame_cnt;
endmodule

// File: tb/tb_pixel_wb_sequencer.sv
// Bench for pixel_wb_sequencer: Wishbone slave + pixel-done model with a write-data scoreboard.
module tb_pixel_wb_sequencer;
  localparam logic [31:0] ADDR = 32'h3000_0000;
  localparam int FW = 8;

  logic          wb_clk_i = 1'b0, wb_rst_i = 1'b1, run_i = 1'b0, pxl_done_i = 1'b0;
  logic [FW-1:0] frames_i = '0;
  logic [23:0]   cfg_i = '0;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 1'b0;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic          busy_o, done_o, err_o;
  logic [1:0]    err_code_o;
  logic [FW-1:0] frame_cnt_o;

  pixel_wb_sequencer #(.ADDR(ADDR), .FRAME_W(FW), .ACK_TIMEOUT(16), .DONE_TIMEOUT(1024)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .run_i(run_i), .frames_i(frames_i), .cfg_i(cfg_i),
    .pxl_done_i(pxl_done_i), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .frame_cnt_o(frame_cnt_o));

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w, last_wr = '0;
  bit ack_en = 1'b1, done_en = 1'b1, rd_zero = 1'b0;
  int ack_lat = 1, done_delay = 5, stb_n = 0, done_cnt = 0, wr_cnt = 0;
  logic pulse;

  function automatic logic [31:0] ctl_word(input logic [23:0] c, input logic start);
    ctl_word = {8'h00, c[23:1], start};
  endfunction

  // slave + pixel macro model; write data is checked against the scoreboard as it is acked
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_ack_i = 1'b0; stb_n = 0; done_cnt = 0; pxl_done_i = 1'b0;
    end else begin
      pulse = 1'b0;
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) pulse = 1'b1;
      end
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
        stb_n = stb_n + 1;
        if (ack_en && stb_n == ack_lat) begin
          wbm_ack_i = 1'b1;
          if (wbm_we_o) begin
            wr_cnt = wr_cnt + 1;
            last_wr = wbm_dat_o;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
              errors = errors + 1;
              $display("FAIL wb_write unexpected write got %h", wbm_dat_o);
            end else begin
              exp_w = exp_q.pop_front();
              if (wbm_dat_o !== exp_w || wbm_adr_o !== ADDR || wbm_sel_o !== 4'hF) begin
                errors = errors + 1;
                $display("FAIL wb_write got dat %h adr %h sel %h exp dat %h adr %h sel f",
                         wbm_dat_o, wbm_adr_o, wbm_sel_o, exp_w, ADDR);
              end
            end
            if (wbm_dat_o[0] && done_en) done_cnt = done_delay;
          end else wbm_dat_i = rd_zero ? 32'h0 : last_wr;
        end
      end else begin
        wbm_ack_i = 1'b0;
        stb_n = 0;
      end
      pxl_done_i = pulse;
    end
  end

  task automatic run_pulse(input logic [FW-1:0] f, input logic [23:0] c);
    @(negedge wb_clk_i);
    frames_i = f; cfg_i = c; run_i = 1'b1;
    @(negedge wb_clk_i);
    run_i = 1'b0;
  endtask

  task automatic push_frames(input int n, input logic [23:0] c);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ctl_word(c, 1'b1));
      exp_q.push_back(ctl_word(c, 1'b0));
    end
  endtask

  task automatic wait_idle(input int budget, output int busy_n, output int cyc_n,
                           output int pulses, output bit to, output bit done_ok);
    busy_n = 0; cyc_n = 0; pulses = 0; to = 1'b1; done_ok = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (wbm_cyc_o) cyc_n++;
      if (done_o) begin
        pulses++;
        if (!busy_o) done_ok = 1'b0;
      end
      if (!busy_o) begin
        to = 1'b0;
        break;
      end
      busy_n++;
      @(negedge wb_clk_i);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o, err_o, err_code_o} !== 11'h0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o, err_o, err_code_o});
    end
    checks++;
    if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || frame_cnt_o !== '0) begin
      errors++; $display("FAIL reset_data got adr %h dat %h cnt %0d exp 0", wbm_adr_o, wbm_dat_o, frame_cnt_o);
    end
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL reset_release got busy %b cyc %b exp 0 0", busy_o, wbm_cyc_o);
    end
  endtask

  task automatic test_frames3;
    int b, c, p; bit to, ok;
    wr_cnt = 0;
    push_frames(3, 24'h00A5A4);
    run_pulse(8'd3, 24'h00A5A4);
    checks++;
    if (busy_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL start_latency_a got busy %b cyc %b exp 1 0", busy_o, wbm_cyc_o);
    end
    @(posedge wb_clk_i); #1;
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1) begin
      errors++; $display("FAIL start_latency_b got cyc %b stb %b we %b exp 1 1 1", wbm_cyc_o, wbm_stb_o, wbm_we_o);
    end
    wait_idle(500, b, c, p, to, ok);
    checks++;
    if (to || p != 1 || !ok) begin
      errors++; $display("FAIL frames3_done got timeout %0d pulses %0d aligned %0d exp 0 1 1", to, p, ok);
    end
    checks++;
    if (frame_cnt_o !== 8'd3 || err_o !== 1'b0 || wr_cnt != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL frames3_result got cnt %0d err %b writes %0d left %0d exp 3 0 6 0", frame_cnt_o, err_o, wr_cnt, exp_q.size());
    end
  endtask

  task automatic test_ack_boundary;
    int b, c, p; bit to, ok;
    ack_lat = 16;
    push_frames(1, 24'hC35AF1);
    run_pulse(8'd1, 24'hC35AF1);
    wait_idle(500, b, c, p, to, ok);
    checks++;
    if (to || p != 1 || err_o !== 1'b0 || frame_cnt_o !== 8'd1 || exp_q.size() != 0) begin
      errors++; $display("FAIL ack_at_limit got timeout %0d pulses %0d err %b cnt %0d left %0d exp 0 1 0 1 0", to, p, err_o, frame_cnt_o, exp_q.size());
    end
    ack_lat = 1;
  endtask

  task automatic test_ack_timeout;
    int b, c, p; bit to, ok;
    ack_en = 1'b0;
    run_pulse(8'd2, 24'h00A5A4);
    wait_idle(200, b, c, p, to, ok);
    checks++;
    if (to || c != 17 || b != 19) begin
      errors++; $display("FAIL ack_timeout_len got timeout %0d cyc %0d busy %0d exp 0 17 19", to, c, b);
    end
    checks++;
    if (err_o !== 1'b1 || err_code_o !== 2'b01 || p != 0 || frame_cnt_o !== 8'd0) begin
      errors++; $display("FAIL ack_timeout_err got err %b code %b pulses %0d cnt %0d exp 1 01 0 0", err_o, err_code_o, p, frame_cnt_o);
    end
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (err_o !== 1'b1 || err_code_o !== 2'b01 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL err_sticky got err %b code %b cyc %b exp 1 01 0", err_o, err_code_o, wbm_cyc_o);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_done_timeout;
    int b, c, p; bit to, ok;
    done_en = 1'b0;
    exp_q.push_back(ctl_word(24'h00A5A4, 1'b1));
    run_pulse(8'd2, 24'h00A5A4);
    wait_idle(1500, b, c, p, to, ok);
    checks++;
    if (to || b != 1027) begin
      errors++; $display("FAIL done_timeout_len got timeout %0d busy %0d exp 0 1027", to, b);
    end
    checks++;
    if (err_o !== 1'b1 || err_code_o !== 2'b10 || frame_cnt_o !== 8'd0 || p != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL done_timeout_err got err %b code %b cnt %0d pulses %0d left %0d exp 1 10 0 0 0", err_o, err_code_o, frame_cnt_o, p, exp_q.size());
    end
    done_en = 1'b1;
  endtask

`ifdef PXL_SEQ_READBACK_EN
  task automatic test_readback;
    int b, c, p; bit to, ok;
    rd_zero = 1'b1;
    push_frames(1, 24'h00A5A4);
    run_pulse(8'd3, 24'h00A5A4);
    wait_idle(500, b, c, p, to, ok);
    checks++;
    if (to || err_o !== 1'b1 || err_code_o !== 2'b11 || frame_cnt_o !== 8'd0 || p != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL readback_err got timeout %0d err %b code %b cnt %0d pulses %0d exp 0 1 11 0 0", to, err_o, err_code_o, frame_cnt_o, p);
    end
    rd_zero = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    int b, c, p; bit to, ok, found;
    found = 1'b0;
    ack_lat = 3;
    exp_q.push_back(ctl_word(24'h123456, 1'b1));
    run_pulse(8'd2, 24'h123456);
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk_i); #1;
      if (wbm_stb_o && wbm_we_o && !wbm_dat_o[0]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_reach got found 0 exp 1");
    end
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_async got cyc %b stb %b busy %b exp 0 0 0", wbm_cyc_o, wbm_stb_o, busy_o);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    ack_lat = 1;
    checks++;
    if (frame_cnt_o !== 8'd0 || err_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_state got cnt %0d err %b left %0d exp 0 0 0", frame_cnt_o, err_o, exp_q.size());
    end
    push_frames(1, 24'h123456);
    run_pulse(8'd1, 24'h123456);
    wait_idle(500, b, c, p, to, ok);
    checks++;
    if (to || p != 1 || frame_cnt_o !== 8'd1 || exp_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_rerun got timeout %0d pulses %0d cnt %0d left %0d exp 0 1 1 0", to, p, frame_cnt_o, exp_q.size());
    end
  endtask

  task automatic test_frames0;
    int b, c, p; bit to, ok;
    wr_cnt = 0;
    push_frames(1, 24'h0F0F0E);
    run_pulse(8'd0, 24'h0F0F0E);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      run_i = 1'b1; frames_i = 8'd5; cfg_i = 24'hFFFFFF;
      @(negedge wb_clk_i);
      run_i = 1'b0;
    end
    wait_idle(500, b, c, p, to, ok);
    checks++;
    if (to || p != 1 || frame_cnt_o !== 8'd1 || wr_cnt != 2 || exp_q.size() != 0 || err_o !== 1'b0) begin
      errors++; $display("FAIL frames0 got timeout %0d pulses %0d cnt %0d writes %0d left %0d err %b exp 0 1 1 2 0 0", to, p, frame_cnt_o, wr_cnt, exp_q.size(), err_o);
    end
  endtask

  initial begin
    test_reset();
    test_frames3();
    test_ack_boundary();
    test_ack_timeout();
    test_done_timeout();
`ifdef PXL_SEQ_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    test_frames0();
    repeat (2) @(negedge wb_clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
